// File: rtl/paint_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// paint_pkg : frame geometry, colour codes and engine states for the paint RAM
// Rev 1.0
// ---------------------------------------------------------------------------
package paint_pkg;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int FRAME_PIXELS = H_RES * V_RES;
  localparam int MAX_SIZE     = 7;

  typedef enum logic [2:0] {
    ERASE  = 3'd0,
    WHITE  = 3'd1,
    BLACK  = 3'd2,
    RED    = 3'd3,
    BLUE   = 3'd4,
    YELLOW = 3'd5,
    GREEN  = 3'd6,
    PURPLE = 3'd7
  } color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/brush_clip.sv
`default_nettype none
// ---------------------------------------------------------------------------
// brush_clip : maps brush centre and half-size to an on-screen bounding box
// Rev 1.0
// ---------------------------------------------------------------------------
module brush_clip #(
  parameter int H_RES    = paint_pkg::H_RES,
  parameter int V_RES    = paint_pkg::V_RES,
  parameter int MAX_SIZE = paint_pkg::MAX_SIZE
) (
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic [2:0] size,
  output logic [9:0] x0,
  output logic [9:0] x1,
  output logic [8:0] y0,
  output logic [8:0] y1,
  output logic       empty
);

  int s;
  int lo_x;
  int hi_x;
  int lo_y;
  int hi_y;

  // Signed integer arithmetic so a brush overhanging the left/top edge cannot wrap.
  always_comb begin
    s    = (int'(size) > MAX_SIZE) ? MAX_SIZE : int'(size);
    lo_x = int'(x) - s;
    hi_x = int'(x) + s;
    lo_y = int'(y) - s;
    hi_y = int'(y) + s;
    if (lo_x < 0)         lo_x = 0;
    if (hi_x > H_RES - 1) hi_x = H_RES - 1;
    if (lo_y < 0)         lo_y = 0;
    if (hi_y > V_RES - 1) hi_y = V_RES - 1;
    x0    = 10'(lo_x);
    x1    = 10'(hi_x);
    y0    = 9'(lo_y);
    y1    = 9'(hi_y);
    empty = (int'(x) >= H_RES) || (int'(y) >= V_RES);
  end

endmodule
`default_nettype wire

// File: rtl/paint_brush_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// paint_brush_writer : paints clipped square brushes or clears the frame RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module paint_brush_writer #(
  parameter int H_RES    = paint_pkg::H_RES,
  parameter int V_RES    = paint_pkg::V_RES,
  parameter int MAX_SIZE = paint_pkg::MAX_SIZE,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [9:0]        req_x,
  input  logic [8:0]        req_y,
  input  logic [2:0]        req_color,
  input  logic [2:0]        req_size,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wren,
  output logic [2:0]        wr_data
);

  import paint_pkg::*;

  localparam logic [ADDR_W-1:0] H_STEP    = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  state_t            state_q, state_d;
  logic [9:0]        col_q, col_d;
  logic [9:0]        x0_q, x0_d;
  logic [9:0]        x1_q, x1_d;
  logic [8:0]        row_q, row_d;
  logic [8:0]        y1_q, y1_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wren_q, wren_d;
  logic [2:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;

  logic [9:0]        clip_x0, clip_x1;
  logic [8:0]        clip_y0, clip_y1;
  logic              clip_empty;
  logic [ADDR_W-1:0] first_base;

  brush_clip #(
    .H_RES    (H_RES),
    .V_RES    (V_RES),
    .MAX_SIZE (MAX_SIZE)
  ) u_brush_clip (
    .x     (req_x),
    .y     (req_y),
    .size  (req_size),
    .x0    (clip_x0),
    .x1    (clip_x1),
    .y0    (clip_y0),
    .y1    (clip_y1),
    .empty (clip_empty)
  );

  // The only multiply: first row base, formed once at accept time.
  assign first_base = ADDR_W'(clip_y0) * H_STEP;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    row_d      = row_q;
    y1_d       = y1_q;
    row_base_d = row_base_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wren_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          wr_addr_d = '0;
          wr_data_d = ERASE;
          wren_d    = 1'b1;
        end else if (req_valid) begin
          state_d    = PAINT;
          x0_d       = clip_x0;
          x1_d       = clip_x1;
          y1_d       = clip_y1;
          col_d      = clip_x0;
          row_d      = clip_y0;
          row_base_d = first_base;
          wr_addr_d  = first_base + ADDR_W'(clip_x0);
          wr_data_d  = req_color;
          wren_d     = !clip_empty;
        end
      end

      // Output registers hold the pixel being written; step to the next one
      // or retire once the current pixel is the last (or the box was empty).
      PAINT: begin
        if (!wren_q || (col_q == x1_q && row_q == y1_q)) begin
          state_d = IDLE;
        end else begin
          wren_d = 1'b1;
          if (col_q == x1_q) begin
            col_d      = x0_q;
            row_d      = row_q + 1'b1;
            row_base_d = row_base_q + H_STEP;
            wr_addr_d  = row_base_q + H_STEP + ADDR_W'(x0_q);
          end else begin
            col_d     = col_q + 1'b1;
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end

      CLEAR: begin
        if (wr_addr_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          wren_d    = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      row_q      <= '0;
      y1_q       <= '0;
      row_base_q <= '0;
      wr_addr_q  <= '0;
      wren_q     <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      row_q      <= row_d;
      y1_q       <= y1_d;
      row_base_q <= row_base_d;
      wr_addr_q  <= wr_addr_d;
      wren_q     <= wren_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = busy_q;
  assign wr_addr   = wr_addr_q;
  assign wren      = wren_q;
  assign wr_data   = wr_data_q;

endmodule
`default_nettype wire
